// File: rtl/rx.sv
// ============================================================================
// rx - 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_START = 2'd1;
  localparam logic [1:0]  S_DATA  = 2'd2;
  localparam logic [1:0]  S_STOP  = 2'd3;
  localparam logic [15:0] HALF_M1 = CLKS_PER_BIT / 16'd2 - 16'd1;
  localparam logic [15:0] FULL_M1 = CLKS_PER_BIT - 16'd1;

  logic        sync1_q, rxs_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        armed_q, armed_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        half_hit, full_hit;

  assign half_hit = (cnt_q == HALF_M1);
  assign full_hit = (cnt_q == FULL_M1);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rxs_q && armed_q) state_d = S_START;
      S_START: if (half_hit) state_d = rxs_q ? S_IDLE : S_DATA;
      S_DATA:  if (full_hit && (idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (full_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output pulses; counter free-runs per bit, never resyncs on edges
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    armed_d = armed_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        if (rxs_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
        end
      end
      S_START: begin
        idx_d = 3'd0;
        cnt_d = half_hit ? 16'd0 : cnt_q + 16'd1;
      end
      S_DATA: begin
        if (full_hit) begin
          cnt_d = 16'd0;
          sh_d  = {rxs_q, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (full_hit) begin
          cnt_d = 16'd0;
          if (rxs_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: cnt_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      armed_q <= 1'b1;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rx_busy  = (state_q != S_IDLE);
    rx_data  = data_q;
    rx_valid = valid_q;
    rx_err   = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rx.sv
// ============================================================================
// tb_rx - self-checking bench for rx: vector table, corner sequences, random loopback
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  rx #(.CLKS_PER_BIT(16'(CPB))) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_valid = 0;
  int         n_err   = 0;
  int         n_both  = 0;
  logic [7:0] rcv_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;

  always @(negedge clk) begin
    if (n_rst) begin
      if (rx_valid) begin
        n_valid++;
        rcv_q.push_back(rx_data);
      end
      if (rx_err) n_err++;
      if (rx_valid && rx_err) n_both++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_rd;
    int         exp_v;
    int         exp_e;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, e0, lat, gap;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 8'hFF, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};

    rxd = 1'b1;
    n_rst = 1'b0;
    exp_data = 8'h00;
    tick(3);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_err", rx_err, 0);
    check("reset rx_busy", rx_busy, 0);
    n_rst = 1'b1;
    tick(5);

    // Single-frame vector table
    for (int i = 0; i < 6; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].data, vecs[i].stop);
      rxd = 1'b1;
      tick(2 * CPB);
      check($sformatf("vec%0d valid pulses", i), n_valid - v0, vecs[i].exp_v);
      check($sformatf("vec%0d err pulses", i), n_err - e0, vecs[i].exp_e);
      check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rd);
      check($sformatf("vec%0d busy idle", i), rx_busy, 0);
    end
    exp_data = 8'h81;

    // Back-to-back frames with no idle gap
    rcv_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    rxd = 1'b1;
    tick(2 * CPB);
    check("b2b count", rcv_q.size(), 3);
    if (rcv_q.size() == 3) begin
      check("b2b byte0", rcv_q[0], 8'h00);
      check("b2b byte1", rcv_q[1], 8'hFF);
      check("b2b byte2", rcv_q[2], 8'h5A);
    end
    exp_data = 8'h5A;

    // Short low glitch while idle
    v0 = n_valid;
    e0 = n_err;
    rxd = 1'b0;
    tick(4);
    check("glitch busy seen", rx_busy, 1);
    tick(1);
    rxd = 1'b1;
    tick(15);
    check("glitch busy cleared", rx_busy, 0);
    check("glitch no valid", n_valid - v0, 0);
    check("glitch no err", n_err - e0, 0);

    // Framing error followed by a line held low
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("hold-low err pulses", n_err - e0, 1);
    check("hold-low no valid", n_valid - v0, 0);
    check("hold-low busy", rx_busy, 0);
    check("hold-low rx_data kept", rx_data, exp_data);
    rxd = 1'b1;
    tick(2 * CPB);
    check("hold-low err after release", n_err - e0, 1);
    check("hold-low busy after release", rx_busy, 0);

    // Start-edge to rx_valid latency
    v0 = n_valid;
    lat = 0;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        while (!rx_valid && lat < 400) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    rxd = 1'b1;
    tick(2 * CPB);
    check("latency in window", int'(lat >= 2 + CPB / 2 + 9 * CPB - 1 && lat <= 2 + CPB / 2 + 9 * CPB + 1), 1);
    check("latency rx_data", rx_data, 8'hC3);
    check("latency one pulse", n_valid - v0, 1);
    exp_data = 8'hC3;

    // Reset in the middle of bit 4 of a frame
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    tick(CPB / 2);
    check("pre-reset busy", rx_busy, 1);
    n_rst = 1'b0;
    #1;
    check("mid reset rx_data", rx_data, 8'h00);
    check("mid reset rx_busy", rx_busy, 0);
    check("mid reset rx_valid", rx_valid, 0);
    check("mid reset rx_err", rx_err, 0);
    tick(3);
    n_rst = 1'b1;
    exp_data = 8'h00;
    tick(3 * CPB);
    check("aborted no valid", n_valid - v0, 0);
    check("aborted no err", n_err - e0, 0);
    check("aborted busy", rx_busy, 0);
    send_frame(8'h81, 1'b1);
    rxd = 1'b1;
    tick(2 * CPB);
    check("post-reset valid", n_valid - v0, 1);
    check("post-reset rx_data", rx_data, 8'h81);

    // Random loopback against a queue of sent bytes
    rcv_q.delete();
    exp_q.delete();
    e0 = n_err;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      exp_q.push_back(b);
      rxd = 1'b1;
      gap = $urandom_range(0, 20);
      if (gap > 0) tick(gap);
    end
    tick(2 * CPB);
    check("random count", rcv_q.size(), exp_q.size());
    check("random err count", n_err - e0, 0);
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      check($sformatf("random byte %0d", i), rcv_q[i], exp_q[i]);
    end

    check("valid and err never together", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
